hazard_scoreboard: RTL and testbench

- Parametrised hazard and forwarding controller for the pipelined MIPS core; sits beside the decode stage.
- Tracks destination tags of in-flight instructions across FWD_DEPTH stages after decode (distance 1 = E, 2 = M, 3 = W).
- Generates load-use and multiply/divide-busy stalls, and registered per-operand forward selects.
- Generalises the fixed distance-one check to N distances, with configurable load latency and a multi-cycle unit.

---
 rtl/hazard_scoreboard.sv | 149 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Hazard and forwarding controller for the pipelined MIPS core, beside decode.
// It tracks the destination tags of in-flight instructions for FWD_DEPTH stages
// after D (distance 1 = E, 2 = M, 3 = W).
// It raises load-use and mult/div-busy stalls.
// It registers per-operand forward selects that line up with the consumer's E stage.
//
// Ports:
//   clk, rst_n                  core clock, async active-low reset
//   id_*_i                      decode-stage instruction description
//   stall_ext_i                 global freeze (memory wait)
//   flush_i                     discard D (taken branch)
//   stall_o / bubble_o          hold PC+D / send NOP into E
//   fwd_a_o / fwd_b_o           0 = regfile, k = producer at distance k
//   md_busy_o                   HI/LO unit occupied
//
// Optional feature macro HAZ_STATS_EN adds two stall counters:
//   stat_lu_o, stat_md_o        saturating counts of non-frozen load-use / md stall cycles
module hazard_scoreboard #(
  parameter int AW        = 5,
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 1,
  parameter int MD_LAT    = 4,
  parameter int FW        = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid_i,
  input  logic [AW-1:0] id_rs_i,
  input  logic [AW-1:0] id_rt_i,
  input  logic          id_use_rs_i,
  input  logic          id_use_rt_i,
  input  logic          id_wr_i,
  input  logic [AW-1:0] id_dst_i,
  input  logic          id_is_load_i,
  input  logic          id_is_md_i,
  input  logic          id_rd_md_i,
  input  logic          stall_ext_i,
  input  logic          flush_i,
  output logic          stall_o,
  output logic          bubble_o,
  output logic [FW-1:0] fwd_a_o,
  output logic [FW-1:0] fwd_b_o,
  output logic          md_busy_o
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]   stat_lu_o,
  output logic [31:0]   stat_md_o
`endif
);

  localparam int MCW = (MD_LAT < 1) ? 1 : $clog2(MD_LAT + 1);

  logic [FWD_DEPTH:1]         r_vld;
  logic [FWD_DEPTH:1]         r_ld;
  logic [FWD_DEPTH:1][AW-1:0] r_dst;
  logic [FW-1:0]              r_fwd_a;
  logic [FW-1:0]              r_fwd_b;
  logic [MCW-1:0]             r_md_cnt;

  logic [FW-1:0] w_sel_a;
  logic [FW-1:0] w_sel_b;
  logic          w_ld_a;
  logic          w_ld_b;
  logic          w_prod;
  logic          w_lu_haz;
  logic          w_md_haz;

  // Scan from the oldest entry towards the newest so the nearest producer
  // overwrites any farther match.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    w_ld_a  = 1'b0;
    w_ld_b  = 1'b0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (id_use_rs_i && r_vld[k] && (r_dst[k] == id_rs_i) && (id_rs_i != '0)) begin
        w_sel_a = FW'(k);
        w_ld_a  = r_ld[k] && (k <= LOAD_LAT);
      end
      if (id_use_rt_i && r_vld[k] && (r_dst[k] == id_rt_i) && (id_rt_i != '0)) begin
        w_sel_b = FW'(k);
        w_ld_b  = r_ld[k] && (k <= LOAD_LAT);
      end
    end
  end

  assign w_prod    = id_valid_i & id_wr_i & (id_dst_i != '0);
  assign md_busy_o = (r_md_cnt != '0);
  assign w_lu_haz  = id_valid_i & (w_ld_a | w_ld_b);
  assign w_md_haz  = id_valid_i & (id_is_md_i | id_rd_md_i) & md_busy_o;
  // A flush discards D, so there is nothing left to stall for.
  assign stall_o   = (w_lu_haz | w_md_haz) & ~flush_i;
  assign bubble_o  = (stall_o | flush_i) & ~stall_ext_i;
  assign fwd_a_o   = r_fwd_a;
  assign fwd_b_o   = r_fwd_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= '0;
      r_ld    <= '0;
      r_dst   <= '0;
      r_fwd_a <= '0;
      r_fwd_b <= '0;
    end else if (!stall_ext_i) begin
      for (int k = FWD_DEPTH; k >= 2; k--) begin
        r_vld[k] <= r_vld[k-1];
        r_ld[k]  <= r_ld[k-1];
        r_dst[k] <= r_dst[k-1];
      end
      r_vld[1] <= w_prod & ~bubble_o;
      r_ld[1]  <= id_is_load_i;
      r_dst[1] <= id_dst_i;
      r_fwd_a  <= bubble_o ? '0 : w_sel_a;
      r_fwd_b  <= bubble_o ? '0 : w_sel_b;
    end
  end

  // The HI/LO unit keeps working through a global freeze, so the counter
  // decrements even when stall_ext_i holds the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_md_cnt <= '0;
    end else if (!stall_ext_i && id_valid_i && id_is_md_i && !bubble_o) begin
      r_md_cnt <= MCW'(MD_LAT);
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - MCW'(1);
    end
  end

`ifdef HAZ_STATS_EN
  logic [31:0] r_stat_lu;
  logic [31:0] r_stat_md;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_lu <= '0;
      r_stat_md <= '0;
    end else if (!stall_ext_i && !flush_i) begin
      if (w_lu_haz && (r_stat_lu != 32'hFFFF_FFFF)) r_stat_lu <= r_stat_lu + 32'd1;
      if (w_md_haz && (r_stat_md != 32'hFFFF_FFFF)) r_stat_md <= r_stat_md + 32'd1;
    end
  end

  assign stat_lu_o = r_stat_lu;
  assign stat_md_o = r_stat_md;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard (default parameters: FWD_DEPTH=3, LOAD_LAT=1, MD_LAT=4).
// The expected forward selects are queued when an instruction is driven.
// They are popped and compared one clock later, when the instruction reaches E.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid_i;
  logic [4:0] id_rs_i, id_rt_i, id_dst_i;
  logic       id_use_rs_i, id_use_rt_i, id_wr_i;
  logic       id_is_load_i, id_is_md_i, id_rd_md_i;
  logic       stall_ext_i, flush_i;
  logic       stall_o, bubble_o, md_busy_o;
  logic [1:0] fwd_a_o, fwd_b_o;
`ifdef HAZ_STATS_EN
  logic [31:0] stat_lu_o, stat_md_o;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  hazard_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid_i   (id_valid_i),
    .id_rs_i      (id_rs_i),
    .id_rt_i      (id_rt_i),
    .id_use_rs_i  (id_use_rs_i),
    .id_use_rt_i  (id_use_rt_i),
    .id_wr_i      (id_wr_i),
    .id_dst_i     (id_dst_i),
    .id_is_load_i (id_is_load_i),
    .id_is_md_i   (id_is_md_i),
    .id_rd_md_i   (id_rd_md_i),
    .stall_ext_i  (stall_ext_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .bubble_o     (bubble_o),
    .fwd_a_o      (fwd_a_o),
    .fwd_b_o      (fwd_b_o),
    .md_busy_o    (md_busy_o)
`ifdef HAZ_STATS_EN
    ,
    .stat_lu_o    (stat_lu_o),
    .stat_md_o    (stat_md_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_d(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ur, input logic ut, input logic wr,
                       input logic [4:0] dst, input logic ld, input logic md,
                       input logic rdmd);
    id_valid_i   = v;
    id_rs_i      = rs;
    id_rt_i      = rt;
    id_use_rs_i  = ur;
    id_use_rt_i  = ut;
    id_wr_i      = wr;
    id_dst_i     = dst;
    id_is_load_i = ld;
    id_is_md_i   = md;
    id_rd_md_i   = rdmd;
    flush_i      = 1'b0;
    stall_ext_i  = 1'b0;
  endtask

  task automatic nop();                                  set_d(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic alu(input logic [4:0] d, s, t);         set_d(1, s, t, 1, 1, 1, d, 0, 0, 0); endtask
  task automatic lw(input logic [4:0] d, base);          set_d(1, base, 0, 1, 0, 1, d, 1, 0, 0); endtask
  task automatic mult(input logic [4:0] s, t);           set_d(1, s, t, 1, 1, 0, 0, 0, 1, 0); endtask
  task automatic mfhi(input logic [4:0] d);              set_d(1, 0, 0, 0, 0, 1, d, 0, 0, 1); endtask

  // Check the combinational outputs mid-cycle.
  // Queue the selects the E stage must show after the edge.
  // Compare them just after that edge.
  task automatic cyc(input logic es, input logic eb, input logic ebusy,
                     input logic [1:0] fa, input logic [1:0] fb);
    logic [3:0] e;
    @(negedge clk);
    chk("stall", stall_o, es);
    chk("bubble", bubble_o, eb);
    chk("md_busy", md_busy_o, ebusy);
    exp_q.push_back({fa, fb});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("fwd_a", fwd_a_o, e[3:2]);
      chk("fwd_b", fwd_b_o, e[1:0]);
    end
  endtask

  task automatic nop3();
    repeat (3) begin
      nop();
      cyc(0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_stall", stall_o, 0);
    chk("rst_bubble", bubble_o, 0);
    chk("rst_fwd_a", fwd_a_o, 0);
    chk("rst_fwd_b", fwd_b_o, 0);
    chk("rst_md_busy", md_busy_o, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Distance-1 ALU forward.
    alu(3, 1, 2);  cyc(0, 0, 0, 0, 0);
    alu(4, 3, 5);  cyc(0, 0, 0, 1, 0);
    nop3();

    // Load-use: one stall cycle, then forward from distance 2.
    lw(6, 1);      cyc(0, 0, 0, 0, 0);
    alu(7, 6, 6);  cyc(1, 1, 0, 0, 0);
    alu(7, 6, 6);  cyc(0, 0, 0, 2, 2);
    nop3();

    // Distance 3 forwards; distance 4 reads the regfile.
    alu(8, 1, 2);  cyc(0, 0, 0, 0, 0);
    nop();         cyc(0, 0, 0, 0, 0);
    nop();         cyc(0, 0, 0, 0, 0);
    alu(9, 8, 8);  cyc(0, 0, 0, 3, 3);
    alu(8, 1, 2);  cyc(0, 0, 0, 0, 0);
    nop3();
    alu(9, 8, 8);  cyc(0, 0, 0, 0, 0);
    nop3();

    // Nearest of two producers of the same register wins.
    alu(10, 1, 2); cyc(0, 0, 0, 0, 0);
    alu(10, 1, 2); cyc(0, 0, 0, 0, 0);
    alu(11, 10, 10); cyc(0, 0, 0, 1, 1);
    nop3();

    // mult then mfhi: four stall cycles while the unit is busy.
    mult(1, 2);    cyc(0, 0, 0, 0, 0);
    repeat (4) begin
      mfhi(12);    cyc(1, 1, 1, 0, 0);
    end
    mfhi(12);      cyc(0, 0, 0, 0, 0);
    nop3();

    // Flush alongside a load-use hazard: no stall, bubble, entry 1 empty.
    lw(6, 1);      cyc(0, 0, 0, 0, 0);
    alu(7, 6, 6);  flush_i = 1'b1; cyc(0, 1, 0, 0, 0);
    alu(13, 7, 6); cyc(0, 0, 0, 0, 2);
    nop3();

    // Global freeze holds the selects and the tags.
    alu(15, 1, 2); cyc(0, 0, 0, 0, 0);
    alu(16, 15, 15); cyc(0, 0, 0, 1, 1);
    alu(17, 16, 15); stall_ext_i = 1'b1; cyc(0, 0, 0, 1, 1);
    alu(17, 16, 15); cyc(0, 0, 0, 1, 2);
    nop3();

    // Load-use under freeze: stall is visible but there is no bubble.
    lw(18, 1);     cyc(0, 0, 0, 0, 0);
    alu(19, 18, 0); stall_ext_i = 1'b1; cyc(1, 0, 0, 0, 0);
    alu(19, 18, 0); cyc(1, 1, 0, 0, 0);
    alu(19, 18, 0); cyc(0, 0, 0, 2, 0);
    nop3();

    // $0 never hazards or forwards.
    lw(0, 1);      cyc(0, 0, 0, 0, 0);
    alu(14, 0, 0); cyc(0, 0, 0, 0, 0);
    nop3();

    // Reset asserted in the middle of a md stall clears it asynchronously.
    mult(1, 2);    cyc(0, 0, 0, 0, 0);
    mfhi(12);
    @(negedge clk);
    chk("md_stall_pre", stall_o, 1);
    chk("md_busy_pre", md_busy_o, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stall", stall_o, 0);
    chk("rst_mid_busy", md_busy_o, 0);
    chk("rst_mid_bubble", bubble_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mfhi(12);      cyc(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
